press_stretcher: RTL and testbench

Converts single-cycle press pulses (as produced by the button debounce/edge stage) back into held, button-like level waveforms, for driving LEDs, external pins, or the input of another button front-end in loopback tests. Each accepted pulse becomes one HIGH window of `HOLD_CYCLES` followed by a LOW gap of `GAP_CYCLES`. Pulses arriving while a window is in progress are queued in a saturating pending counter and replayed back-to-back.

---
 rtl/press_stretcher.sv | 110 +++++++++++
 tb/tb_press_stretcher.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/press_stretcher.sv
// Turns single-cycle press pulses into HIGH windows followed by a LOW gap.
// Pulses that arrive while a window is running are queued and replayed back-to-back.
module press_stretcher #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 2,
   parameter int unsigned PEND_W      = 3
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              pulse_i,
   output logic              level_o,
   output logic              busy_o,
   output logic [PEND_W-1:0] pending_o,
   output logic              overflow_o
);

   localparam int unsigned CntMax = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

   localparam logic [CntW-1:0]   HoldLoad = CntW'(HOLD_CYCLES - 1);
   localparam logic [CntW-1:0]   GapLoad  = CntW'(GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] PendMax  = '1;

   typedef enum logic [1:0] {StIdle, StHigh, StGap} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              level_q, busy_q, ovf_q;
   logic              queue_req;
   logic              drop;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      queue_req = 1'b0;
      drop      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (pulse_i) begin
               state_d = StHigh;
               cnt_d   = HoldLoad;
            end
         end
         StHigh: begin
            queue_req = pulse_i;
            if (cnt_q == '0) begin
               state_d = StGap;
               cnt_d   = GapLoad;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StGap: begin
            if (cnt_q == '0) begin
               // Last gap cycle: a queued press starts now; a new pulse either
               // replaces the one being dequeued or is consumed directly.
               if (pend_q != '0) begin
                  state_d = StHigh;
                  cnt_d   = HoldLoad;
                  if (!pulse_i) pend_d = pend_q - 1'b1;
               end else if (pulse_i) begin
                  state_d = StHigh;
                  cnt_d   = HoldLoad;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d     = cnt_q - 1'b1;
               queue_req = pulse_i;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      if (queue_req) begin
         if (pend_q != PendMax) pend_d = pend_q + 1'b1;
         else                   drop   = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         pend_q  <= '0;
         level_q <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         level_q <= (state_d == StHigh);
         busy_q  <= (state_d != StIdle);
         ovf_q   <= drop;
      end
   end

   assign level_o    = level_q;
   assign busy_o     = busy_q;
   assign pending_o  = pend_q;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_press_stretcher.sv
// Scoreboard bench: stimulus pushes per-cycle expectations from hand-written
// waveform strings; a negedge monitor pops and compares against the DUT.
module tb_press_stretcher;

   typedef struct {
      bit         sel;
      string      name;
      int         cyc;
      logic       lvl;
      logic       bsy;
      logic       ovf;
      logic [2:0] pend;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic pulse   = 1'b0;

   logic       a_level, a_busy, a_ovf;
   logic [2:0] a_pend;
   logic       b_level, b_busy, b_ovf;
   logic [2:0] b_pend;

   always #5 clk = ~clk;

   press_stretcher #(
      .HOLD_CYCLES (4),
      .GAP_CYCLES  (2),
      .PEND_W      (3)
   ) dut_a (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .pulse_i    (pulse),
      .level_o    (a_level),
      .busy_o     (a_busy),
      .pending_o  (a_pend),
      .overflow_o (a_ovf)
   );

   press_stretcher #(
      .HOLD_CYCLES (1),
      .GAP_CYCLES  (1),
      .PEND_W      (3)
   ) dut_b (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .pulse_i    (pulse),
      .level_o    (b_level),
      .busy_o     (b_busy),
      .pending_o  (b_pend),
      .overflow_o (b_ovf)
   );

   function automatic string rep(string s, int n);
      string r;
      r = "";
      for (int i = 0; i < n; i++) r = {r, s};
      return r;
   endfunction

   task automatic check(string name, string field, int cyc, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s %s cycle %0d: got %0d expected %0d", name, field, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         if (!e.sel) begin
            check(e.name, "level",    e.cyc, int'(a_level), int'(e.lvl));
            check(e.name, "busy",     e.cyc, int'(a_busy),  int'(e.bsy));
            check(e.name, "pending",  e.cyc, int'(a_pend),  int'(e.pend));
            check(e.name, "overflow", e.cyc, int'(a_ovf),   int'(e.ovf));
         end else begin
            check(e.name, "level",    e.cyc, int'(b_level), int'(e.lvl));
            check(e.name, "busy",     e.cyc, int'(b_busy),  int'(e.bsy));
            check(e.name, "pending",  e.cyc, int'(b_pend),  int'(e.pend));
            check(e.name, "overflow", e.cyc, int'(b_ovf),   int'(e.ovf));
         end
      end
   end

   task automatic push(bit sel, string name, int cyc, logic l, logic b, logic o, logic [2:0] p);
      exp_t e;
      e.sel  = sel;
      e.name = name;
      e.cyc  = cyc;
      e.lvl  = l;
      e.bsy  = b;
      e.ovf  = o;
      e.pend = p;
      q.push_back(e);
   endtask

   task automatic step(bit p, bit r);
      pulse = p;
      rst_n = r;
      @(posedge clk);
      #1;
   endtask

   // Character i of each string is the value during cycle i of the test.
   task automatic run(bit sel, string name, string pul, string rst, string lvl,
                      string bsy, string pnd, string ovf);
      repeat (2) begin
         step(1'b0, 1'b0);
         push(sel, {name, "/reset"}, -1, 1'b0, 1'b0, 1'b0, 3'd0);
      end
      for (int i = 0; i < pul.len() - 1; i++) begin
         step(pul[i] == "1", rst[i] == "1");
         push(sel, name, i + 1, lvl[i+1] == "1", bsy[i+1] == "1", ovf[i+1] == "1",
              3'(pnd[i+1] - "0"));
      end
   endtask

   initial begin
      run(1'b0, "single",
          "1000000000",
          "1111111111",
          "0111100000",
          "0111111000",
          "0000000000",
          "0000000000");

      run(1'b0, "three_queued",
          "111000000000000000000",
          "111111111111111111111",
          "011110011110011110000",
          {"0", rep("1", 18), "00"},
          "001222211111100000000",
          rep("0", 21));

      run(1'b0, "last_gap_direct",
          "10000010000000",
          "11111111111111",
          "01111001111000",
          "01111111111110",
          "00000000000000",
          "00000000000000");

      run(1'b0, "saturate",
          {rep("1", 11), rep("0", 46)},
          rep("1", 57),
          {"0", rep("111100", 9), "00"},
          {"0", rep("1", 54), "00"},
          {"00", "1234556", "7777", rep("6", 6), rep("5", 6), rep("4", 6), rep("3", 6),
           rep("2", 6), rep("1", 6), rep("0", 8)},
          {rep("0", 10), "11", rep("0", 45)});

      run(1'b0, "reset_mid_window",
          "1010000000",
          "1101111111",
          "0110000000",
          "0110000000",
          "0000000000",
          "0000000000");

      run(1'b1, "hold1_gap1",
          "1110000000",
          "1111111111",
          "0101010000",
          "0111111000",
          "0011100000",
          "0000000000");

      step(1'b0, 1'b1);
      @(negedge clk);
      #1;
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
